// File: rtl/change_dispenser.sv
// Greedy largest-first change payout over 15 denominations, one coin per valid/ready handshake.
// Optional macro VM_CHANGE_PRECHECK_EN adds a shadow greedy pass that refuses payouts it cannot complete.
module change_dispenser #(
  parameter int AMT_W      = 20,
  parameter int COUNT_W    = 8,
  parameter int INIT_COUNT = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AMT_W-1:0]   change_amt,
  output logic               coin_valid,
  output logic [3:0]         coin_code,
  input  logic               coin_ready,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [AMT_W-1:0]   remaining,
  input  logic               refill_valid,
  input  logic [3:0]         refill_code,
  input  logic [COUNT_W-1:0] refill_qty,
  output logic [14:0]        inv_empty
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

`ifdef VM_CHANGE_PRECHECK_EN
  typedef enum logic [2:0] {IDLE, SCAN, EMIT, FIN, PRECHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;
`endif

  function automatic logic [AMT_W-1:0] coin_value(input logic [3:0] code);
    case (code)
      4'd1:    coin_value = AMT_W'(50000);
      4'd2:    coin_value = AMT_W'(20000);
      4'd3:    coin_value = AMT_W'(10000);
      4'd4:    coin_value = AMT_W'(5000);
      4'd5:    coin_value = AMT_W'(2000);
      4'd6:    coin_value = AMT_W'(1000);
      4'd7:    coin_value = AMT_W'(500);
      4'd8:    coin_value = AMT_W'(200);
      4'd9:    coin_value = AMT_W'(100);
      4'd10:   coin_value = AMT_W'(50);
      4'd11:   coin_value = AMT_W'(25);
      4'd12:   coin_value = AMT_W'(10);
      4'd13:   coin_value = AMT_W'(5);
      4'd14:   coin_value = AMT_W'(2);
      4'd15:   coin_value = AMT_W'(1);
      default: coin_value = '0;
    endcase
  endfunction

  // The carry bit of count+qty(-1) flags overflow past the counter range.
  function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W:0] sum);
    sat_count = sum[COUNT_W] ? CNT_MAX : sum[COUNT_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic               coin_valid_q, coin_valid_d;
  logic [3:0]         coin_code_q, coin_code_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic [COUNT_W-1:0] count_q [15];
  logic [COUNT_W-1:0] count_d [15];
  logic               dispense;
  logic [AMT_W-1:0]   cur_val;
  logic [COUNT_W-1:0] cur_cnt;

`ifdef VM_CHANGE_PRECHECK_EN
  logic [AMT_W-1:0]   shadow_rem_q, shadow_rem_d;
  logic [COUNT_W-1:0] shadow_cnt_q [15];
  logic [COUNT_W-1:0] shadow_cnt_d [15];
  logic [COUNT_W-1:0] shadow_cur;
  logic [AMT_W-1:0]   units, take;

  // Constant divisor per branch keeps each quotient a fixed-divisor divide.
  always_comb begin
    shadow_cur = '0;
    units      = '0;
    for (int k = 0; k < 15; k++) begin
      if (idx_q == 4'(k + 1)) begin
        shadow_cur = shadow_cnt_q[k];
        units      = shadow_rem_q / coin_value(4'(k + 1));
      end
    end
    take = (units > AMT_W'(shadow_cur)) ? AMT_W'(shadow_cur) : units;
  end
`endif

  always_comb begin
    cur_val = coin_value(idx_q);
    cur_cnt = '0;
    for (int k = 0; k < 15; k++)
      if (idx_q == 4'(k + 1)) cur_cnt = count_q[k];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    remaining_d  = remaining_q;
    coin_valid_d = coin_valid_q;
    coin_code_d  = coin_code_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    dispense     = 1'b0;
`ifdef VM_CHANGE_PRECHECK_EN
    shadow_rem_d = shadow_rem_q;
    shadow_cnt_d = shadow_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = change_amt;
          idx_d       = 4'd1;
          if (change_amt == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
`ifdef VM_CHANGE_PRECHECK_EN
            state_d      = PRECHECK;
            shadow_rem_d = change_amt;
            shadow_cnt_d = count_q;
`else
            state_d = SCAN;
`endif
          end
        end
      end
`ifdef VM_CHANGE_PRECHECK_EN
      PRECHECK: begin
        shadow_rem_d = shadow_rem_q - take * cur_val;
        if (idx_q == 4'd15) begin
          idx_d = 4'd1;
          if (shadow_rem_d != '0) begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      SCAN: begin
        if (remaining_q >= cur_val && cur_cnt != '0) begin
          state_d      = EMIT;
          coin_valid_d = 1'b1;
          coin_code_d  = idx_q;
        end else if (idx_q == 4'd15) begin
          state_d = IDLE;
          fail_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      EMIT: begin
        if (coin_ready) begin
          coin_valid_d = 1'b0;
          dispense     = 1'b1;
          remaining_d  = remaining_q - cur_val;
          if (remaining_d == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Refill and dispense on the same code combine before saturation.
  always_comb begin
    logic [COUNT_W:0] sum;
    for (int k = 0; k < 15; k++) begin
      sum = {1'b0, count_q[k]};
      if (refill_valid && refill_code == 4'(k + 1)) sum = sum + {1'b0, refill_qty};
      if (dispense && idx_q == 4'(k + 1)) sum = sum - 1'b1;
      count_d[k]   = sat_count(sum);
      inv_empty[k] = (count_q[k] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      remaining_q  <= '0;
      coin_valid_q <= 1'b0;
      coin_code_q  <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int k = 0; k < 15; k++) count_q[k] <= COUNT_W'(INIT_COUNT);
`ifdef VM_CHANGE_PRECHECK_EN
      shadow_rem_q <= '0;
      for (int k = 0; k < 15; k++) shadow_cnt_q[k] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      coin_code_q  <= coin_code_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
`ifdef VM_CHANGE_PRECHECK_EN
      shadow_rem_q <= shadow_rem_d;
      shadow_cnt_q <= shadow_cnt_d;
`endif
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_code  = coin_code_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign remaining  = remaining_q;

endmodule
